// File: rtl/ili9341_pkg.sv
// Shared types and frame geometry for the ILI9341 display pipeline.
package ili9341_pkg;

  localparam int ROWS       = 320;
  localparam int COLS       = 240;
  localparam int NUM_PIXELS = ROWS * COLS;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // One FIFO slot: the pixel plus its start-of-frame tag.
  typedef struct packed {
    logic    sof;
    rgb565_t pixel;
  } fifoEntry_t;

  typedef enum logic [1:0] {
    WAIT_SOF,
    STREAM,
    RESYNC,
    DISCARD
  } frameState_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is readable without a pop.
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     rdEn,
  output logic [WIDTH-1:0]         rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             push;
  logic             pop;

  // A full FIFO refuses the write even when a read frees a slot that cycle.
  assign push  = wrEn & !full;
  assign pop   = rdEn & !empty;
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign count = wrPtr - rdPtr;
  assign rdData = mem[rdPtr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // slots hold valid data, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/rgb565_frame_fifo.sv
// Frame-aware pixel buffer feeding the ILI9341 driver; pops on pixelAddr
// increments and realigns the driver to incoming start-of-frame markers.
module rgb565_frame_fifo #(
  parameter int DEPTH      = 64,
  parameter int NUM_PIXELS = ili9341_pkg::NUM_PIXELS,
  parameter int ADDR_W     = 17
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              s_pixel,
  input  logic                     s_sof,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     pixelPhase,
  input  logic [ADDR_W-1:0]        pixelAddr,
  output logic [15:0]              pixelDataOut,
  output logic                     dataReady,
  output logic                     newFrameStrobe,
  output logic                     frameShort,
  output logic                     frameLong,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fillLevel
);

  import ili9341_pkg::*;

  localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(NUM_PIXELS);

  frameState_t       state, stateNext;
  fifoEntry_t        wrEntry, head;
  logic              fifoFull, fifoEmpty, pop, consume;
  logic              dataReadyQ;
  logic [ADDR_W-1:0] prevAddr;
  logic [ADDR_W-1:0] outCount, outCountNext;
  logic              setShort, setLong, setUnder;
  logic              atFrameEnd, midFrame;

  assign wrEntry = {s_sof, s_pixel};

  sync_fifo #(
    .WIDTH($bits(fifoEntry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (s_valid),
    .wrData (wrEntry),
    .rdEn   (pop),
    .rdData (head),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fillLevel)
  );

  assign s_ready      = !fifoFull;
  assign pixelDataOut = fifoEmpty ? 16'h0000 : head.pixel;

  // The driver latched the head one cycle ago and has now stepped its address;
  // a step back to 0 is a frame restart, not a consumption.
  assign consume = pixelPhase & dataReadyQ & (pixelAddr != '0) &
                   (pixelAddr == prevAddr + ADDR_W'(1));

  assign atFrameEnd = (outCount == FRAME_END);
  assign midFrame   = (outCount != '0) && !atFrameEnd;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    stateNext      = state;
    outCountNext   = outCount;
    pop            = 1'b0;
    dataReady      = 1'b0;
    newFrameStrobe = 1'b0;
    setShort       = 1'b0;
    setLong        = 1'b0;
    setUnder       = 1'b0;
    unique case (state)
      WAIT_SOF: begin
        if (!fifoEmpty) begin
          if (head.sof) begin
            stateNext    = STREAM;
            outCountNext = '0;
          end else begin
            pop = 1'b1;
          end
        end
      end
      STREAM: begin
        dataReady = !fifoEmpty && !(head.sof && outCount != '0);
        if (fifoEmpty) begin
          if (pixelPhase && midFrame) setUnder = 1'b1;
        end else if (head.sof && atFrameEnd) begin
          outCountNext = '0;
        end else if (head.sof && outCount != '0) begin
          setShort  = 1'b1;
          stateNext = RESYNC;
        end else if (atFrameEnd) begin
          setLong   = 1'b1;
          stateNext = DISCARD;
        end else if (consume) begin
          pop          = 1'b1;
          outCountNext = head.sof ? ADDR_W'(1) : outCount + ADDR_W'(1);
        end
      end
      RESYNC: begin
        newFrameStrobe = 1'b1;
        outCountNext   = '0;
        stateNext      = STREAM;
      end
      DISCARD: begin
        if (!fifoEmpty) begin
          if (head.sof) begin
            outCountNext = '0;
            stateNext    = STREAM;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: stateNext = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= WAIT_SOF;
      prevAddr   <= '0;
      dataReadyQ <= 1'b0;
      outCount   <= '0;
      frameShort <= 1'b0;
      frameLong  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= stateNext;
      prevAddr   <= pixelAddr;
      dataReadyQ <= dataReady;
      outCount   <= outCountNext;
      if (setShort) frameShort <= 1'b1;
      if (setLong)  frameLong  <= 1'b1;
      if (setUnder) underrun   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb565_frame_fifo.sv
// Self-checking bench for rgb565_frame_fifo with a paced driver model and a
// pixel scoreboard; frame length is shortened to keep runs brief.
module tb_rgb565_frame_fifo;

  localparam int DEPTH  = 64;
  localparam int NPIX   = 200;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       s_pixel;
  logic              s_sof;
  logic              s_valid;
  logic              s_ready;
  logic              pixelPhase;
  logic [ADDR_W-1:0] pixelAddr;
  logic [15:0]       pixelDataOut;
  logic              dataReady;
  logic              newFrameStrobe;
  logic              frameShort;
  logic              frameLong;
  logic              underrun;
  logic [6:0]        fillLevel;

  rgb565_frame_fifo #(
    .DEPTH(DEPTH), .NUM_PIXELS(NPIX), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .s_pixel(s_pixel), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
    .pixelPhase(pixelPhase), .pixelAddr(pixelAddr),
    .pixelDataOut(pixelDataOut), .dataReady(dataReady),
    .newFrameStrobe(newFrameStrobe), .frameShort(frameShort),
    .frameLong(frameLong), .underrun(underrun), .fillLevel(fillLevel)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        sof;
    logic [15:0] pix;
    bit          keep;
  } beat_t;

  typedef struct {
    logic              v;
    logic              sof;
    logic [15:0]       pix;
    logic              phase;
    logic [ADDR_W-1:0] addr;
    logic [6:0]        expFill;
    logic              expReady;
    logic              expDr;
    logic [15:0]       expPix;
  } vec_t;

  beat_t       srcQ[$];
  logic [15:0] expQ[$];
  vec_t        vecs[7];
  int          nChecks = 0;
  int          nFails  = 0;
  bit          phaseOn, incPending;
  int          drvBudget, strobeCnt, fillN;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_pixel = '0;
    pixelPhase = 1'b0; pixelAddr = '0;
    phaseOn = 0; incPending = 0; drvBudget = 0; strobeCnt = 0;
    srcQ.delete(); expQ.delete();
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic queueFrame(input int nBeats, input int nKeep, input bit withSof);
    for (int i = 0; i < nBeats; i++)
      srcQ.push_back('{sof: (withSof && i == 0), pix: 16'($urandom), keep: (i < nKeep)});
  endtask

  // One clock of source + driver. The driver latches the head while
  // dataReady is high, then steps its address the following cycle.
  task automatic step();
    bit accept;
    if (srcQ.size() > 0) begin
      s_valid = 1'b1; s_sof = srcQ[0].sof; s_pixel = srcQ[0].pix;
    end else begin
      s_valid = 1'b0; s_sof = 1'b0; s_pixel = '0;
    end
    accept = s_valid && s_ready;
    pixelPhase = phaseOn;
    if (newFrameStrobe) begin
      strobeCnt++;
      pixelAddr  = '0;
      incPending = 0;
    end else if (incPending) begin
      pixelAddr  = pixelAddr + 1'b1;
      incPending = 0;
    end else if (pixelAddr == ADDR_W'(NPIX)) begin
      pixelAddr = '0;
    end else if (phaseOn && dataReady && drvBudget > 0) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL pixel: got 0x%0h while no pixel was expected", pixelDataOut);
      end else begin
        check("pixel", pixelDataOut, expQ.pop_front());
      end
      drvBudget--;
      incPending = 1;
    end
    tick();
    if (accept) begin
      if (srcQ[0].keep) expQ.push_back(srcQ[0].pix);
      void'(srcQ.pop_front());
    end
  endtask

  task automatic runUntil(input string name, input int maxCycles);
    int n = 0;
    while ((drvBudget > 0 || incPending) && n < maxCycles) begin
      step();
      n++;
    end
    check({name, " budget left"}, drvBudget, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    doReset();
    check("rst s_ready", s_ready, 1);
    check("rst pixelDataOut", pixelDataOut, 0);
    check("rst dataReady", dataReady, 0);
    check("rst strobe", newFrameStrobe, 0);
    check("rst flags", {frameShort, frameLong, underrun}, 0);
    check("rst fillLevel", fillLevel, 0);

    // WAIT_SOF discards three leading beats, then a consume pops the SOF.
    vecs[0] = '{1'b1, 1'b0, 16'h07E0, 1'b0, 17'd0, 7'd1, 1'b1, 1'b0, 16'h07E0};
    vecs[1] = '{1'b1, 1'b0, 16'h001F, 1'b0, 17'd0, 7'd1, 1'b1, 1'b0, 16'h001F};
    vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 1'b0, 17'd0, 7'd1, 1'b1, 1'b0, 16'hFFFF};
    vecs[3] = '{1'b1, 1'b1, 16'hF800, 1'b0, 17'd0, 7'd1, 1'b1, 1'b0, 16'hF800};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 17'd0, 7'd1, 1'b1, 1'b1, 16'hF800};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 17'd0, 7'd1, 1'b1, 1'b1, 16'hF800};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 17'd1, 7'd0, 1'b1, 1'b0, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      s_valid = vecs[i].v; s_sof = vecs[i].sof; s_pixel = vecs[i].pix;
      pixelPhase = vecs[i].phase; pixelAddr = vecs[i].addr;
      tick();
      check($sformatf("vec%0d fillLevel", i), fillLevel, vecs[i].expFill);
      check($sformatf("vec%0d s_ready", i), s_ready, vecs[i].expReady);
      check($sformatf("vec%0d dataReady", i), dataReady, vecs[i].expDr);
      check($sformatf("vec%0d pixelDataOut", i), pixelDataOut, vecs[i].expPix);
    end
    pixelPhase = 1'b0; s_valid = 1'b0;
    tick();
    check("vec flags", {frameShort, frameLong, underrun}, 0);

    // Full frame followed by the next SOF: clean boundary, no strobe.
    doReset();
    queueFrame(NPIX, NPIX, 1);
    queueFrame(4, 4, 1);
    phaseOn = 1; drvBudget = NPIX + 1;
    runUntil("full frame", 2000);
    phaseOn = 0;
    step();
    check("full strobes", strobeCnt, 0);
    check("full flags", {frameShort, frameLong, underrun}, 0);
    check("full leftover", expQ.size(), 3);

    // SOF arrives after 100 pixels: one strobe, frameShort, new frame streams.
    doReset();
    queueFrame(100, 100, 1);
    queueFrame(NPIX, NPIX, 1);
    phaseOn = 1; drvBudget = 100 + NPIX;
    runUntil("short frame", 3000);
    check("short frameShort", frameShort, 1);
    check("short strobes", strobeCnt, 1);
    check("short other flags", {frameLong, underrun}, 0);
    check("short leftover", expQ.size(), 0);

    // Five extra pixels past frame end are dropped until the next SOF.
    doReset();
    queueFrame(NPIX + 5, NPIX, 1);
    queueFrame(4, 4, 1);
    phaseOn = 1; drvBudget = NPIX + 1;
    runUntil("long frame", 2000);
    phaseOn = 0;
    step();
    check("long frameLong", frameLong, 1);
    check("long other flags", {frameShort, underrun}, 0);
    check("long strobes", strobeCnt, 0);
    check("long leftover", expQ.size(), 3);

    // Source stalls after 10 pixels with the driver waiting, then resumes.
    doReset();
    queueFrame(10, 10, 1);
    phaseOn = 1; drvBudget = 10;
    runUntil("stall head", 200);
    repeat (6) step();
    check("stall underrun", underrun, 1);
    check("stall dataReady", dataReady, 0);
    queueFrame(NPIX - 10, NPIX - 10, 0);
    drvBudget = NPIX - 10;
    runUntil("stall resume", 2000);
    check("resume leftover", expQ.size(), 0);
    check("resume flags", {frameShort, frameLong, underrun}, 3'b001);
    check("resume strobes", strobeCnt, 0);

    // Fill to DEPTH, pop while full with s_valid held, then reset mid-frame.
    doReset();
    fillN = 0;
    s_valid = 1'b1; s_sof = 1'b1; s_pixel = 16'h1000;
    while (s_ready && fillN < 100) begin
      tick();
      fillN++;
      s_sof = 1'b0;
      s_pixel = 16'h1000 + 16'(fillN);
    end
    check("fill accepted", fillN, DEPTH);
    check("fill fillLevel", fillLevel, DEPTH);
    check("fill s_ready", s_ready, 0);
    check("fill head", pixelDataOut, 16'h1000);
    pixelPhase = 1'b1; pixelAddr = 17'd1;
    tick();
    check("full-pop fillLevel", fillLevel, DEPTH - 1);
    check("full-pop head", pixelDataOut, 16'h1001);
    tick();
    check("refill fillLevel", fillLevel, DEPTH);
    check("refill s_ready", s_ready, 0);
    reset = 1'b0;
    tick();
    check("midrst fillLevel", fillLevel, 0);
    check("midrst s_ready", s_ready, 1);
    check("midrst outputs", {dataReady, newFrameStrobe, pixelDataOut}, 0);
    check("midrst flags", {frameShort, frameLong, underrun}, 0);
    pixelPhase = 1'b0; pixelAddr = '0;
    s_sof = 1'b0; s_pixel = 16'hABCD;
    reset = 1'b1;
    tick();
    check("post-rst push", fillLevel, 1);
    s_valid = 1'b0;
    tick();
    check("post-rst discard", fillLevel, 0);
    check("post-rst dataReady", dataReady, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
